// File: rtl/serial_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : serial_transmitter
// Description : 8N1 UART-style transmitter with a small byte FIFO. Bytes are
//               pushed through a valid/ready handshake and serialized LSB
//               first (start, 8 data, STOP_BITS stop bits). Queued bytes are
//               sent back-to-back without any idle gap between frames.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_transmitter #(
  parameter int CLKS_PER_BIT = 4,  // clk_x4 cycles per serial bit, 2..16
  parameter int STOP_BITS    = 1,  // 1 or 2
  parameter int FIFO_LOG2    = 2   // log2 of FIFO depth, 1..4
) (
  input  logic       clk_x4,
  input  logic       rst_x,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_empty
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  // Wide enough for the longest stop period (2 * 16 cycles).
  localparam int CNT_W = 6;

  localparam logic [CNT_W-1:0]     BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]     STOP_LAST = CNT_W'(STOP_BITS * CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]     CNT_ONE   = CNT_W'(1);
  localparam logic [FIFO_LOG2-1:0] PTR_ONE   = FIFO_LOG2'(1);
  localparam logic [FIFO_LOG2:0]   COUNT_ONE = (FIFO_LOG2 + 1)'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t               state;
  logic [7:0]           shift;
  logic [CNT_W-1:0]     clk_cnt;
  logic [2:0]           bit_cnt;

  logic [7:0]           mem [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr;
  logic [FIFO_LOG2-1:0] rd_ptr;
  logic [FIFO_LOG2:0]   count;

  logic                 has_data;
  logic                 stop_end;
  logic                 push;
  logic                 pop;
  logic [7:0]           head;

  // Status flags come straight from the registered count so they never
  // depend on same-cycle handshake activity. Count reaches DEPTH exactly
  // when its top bit is set.
  assign o_ready  = ~count[FIFO_LOG2];
  assign o_empty  = (count == '0);
  assign has_data = (count != '0);
  assign head     = mem[rd_ptr];

  // A pop happens when an idle transmitter sees data, or when the last stop
  // cycle ends with data waiting (chaining straight into the next start bit).
  assign stop_end = (state == STOP) && (clk_cnt == STOP_LAST);
  assign push     = i_valid && o_ready;
  assign pop      = has_data && ((state == IDLE) || stop_end);

  // FIFO storage write; contents need no reset since count guards reads.
  always_ff @(posedge clk_x4) begin
    if (push) begin
      mem[wr_ptr] <= i_data;
    end
  end

  // FIFO pointer and occupancy bookkeeping.
  always_ff @(posedge clk_x4 or negedge rst_x) begin
    if (!rst_x) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer with registered line and busy outputs.
  always_ff @(posedge clk_x4 or negedge rst_x) begin
    if (!rst_x) begin
      state   <= IDLE;
      shift   <= '0;
      clk_cnt <= '0;
      bit_cnt <= '0;
      o_tx    <= 1'b1;
      o_busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (has_data) begin
            shift   <= head;
            clk_cnt <= '0;
            bit_cnt <= '0;
            state   <= START;
            o_tx    <= 1'b0;
            o_busy  <= 1'b1;
          end else begin
            o_tx   <= 1'b1;
            o_busy <= 1'b0;
          end
        end

        START: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            state   <= DATA;
            o_tx    <= shift[0];
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end

        DATA: begin
          if (clk_cnt == BIT_LAST) begin
            clk_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              bit_cnt <= '0;
              state   <= STOP;
              o_tx    <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              o_tx    <= shift[1];
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end

        STOP: begin
          if (clk_cnt == STOP_LAST) begin
            clk_cnt <= '0;
            if (has_data) begin
              // Next byte goes out immediately: no idle cycle between frames.
              shift   <= head;
              bit_cnt <= '0;
              state   <= START;
              o_tx    <= 1'b0;
            end else begin
              state  <= IDLE;
              o_tx   <= 1'b1;
              o_busy <= 1'b0;
            end
          end else begin
            clk_cnt <= clk_cnt + CNT_ONE;
          end
        end

        default: begin
          state  <= IDLE;
          o_tx   <= 1'b1;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
